cak_tag_port_arb: RTL and testbench

- Sequences and shares the cache tag/valid RAM write port between three requesters:
  - CMI snoop invalidates (DMA writes by other masters);
  - CPU cache lookups;
  - a full-cache flush sweep started by microcode (cache-invalidate write-control decode).
- Sits beside the cache control chip logic.
- Drives the tag index mux select and per-group write strobes that are ORed into the existing group-write/valid-clear paths.

---
 rtl/cak_tag_port_arb_pkg.sv | 20 ++
 rtl/cak_sweep_ctr.sv | 37 +++
 rtl/cak_tag_port_arb.sv | 147 ++++++++++++++
 tb/tb_cak_tag_port_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cak_tag_port_arb_pkg.sv
// Shared encodings and defaults for the cache tag/valid write-port arbiter.
package cak_tag_port_arb_pkg;

  localparam int unsigned IDX_W_DEF      = 8;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned ST_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_SNP_WR = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_CPU   = 2'b00,
    SEL_SWEEP = 2'b01,
    SEL_SNOOP = 2'b10
  } tag_sel_e;

endpackage

// File: rtl/cak_sweep_ctr.sv
// Flush sweep index counter: restartable, wraps at the last set, and
// registers a one-clock done pulse when the final index is written.
module cak_sweep_ctr #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             b_clk_l,
  input  logic             proc_init_h,
  input  logic             restart_h,
  input  logic             adv_h,
  output logic [IDX_W-1:0] idx_h,
  output logic             last_h,
  output logic             done_h
);

  logic [IDX_W-1:0] idx_q;
  logic             done_q;

  assign idx_h  = idx_q;
  assign last_h = &idx_q;
  assign done_h = done_q;

  // Restart wins over advance so an aborted pass never signals done.
  always_ff @(posedge b_clk_l) begin
    if (proc_init_h) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= adv_h & last_h & ~restart_h;
      if (restart_h) begin
        idx_q <= '0;
      end else if (adv_h) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/cak_tag_port_arb.sv
// Tag/valid RAM write-port arbiter: snoop invalidates, CPU lookups and a
// microcode-started full-cache invalidate sweep share one index/strobe port.
module cak_tag_port_arb
  import cak_tag_port_arb_pkg::*;
#(
  parameter int unsigned IDX_W      = IDX_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             b_clk_l,
  input  logic             proc_init_h,
  input  logic             d_clk_en_h,
  input  logic             flush_req_h,
  input  logic             snoop_req_h,
  input  logic [IDX_W-1:0] snoop_idx_h,
  input  logic [1:0]       hit_h,
  input  logic             cpu_req_h,
  input  logic [IDX_W-1:0] cpu_idx_h,
  output logic [IDX_W-1:0] tag_idx_h,
  output logic [1:0]       tag_sel_h,
  output logic [1:0]       grp_wr_h,
  output logic             cpu_gnt_h,
  output logic             snoop_ack_h,
  output logic             flush_busy_h,
  output logic             flush_done_h
);

  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_MAX);

  arb_state_e       state_q;
  logic [ST_W-1:0]  st_q;
  logic [1:0]       hit_q;
  logic             ret_sweep_q;

  logic [IDX_W-1:0] idx_q;
  logic             last_h;
  logic             done_h;

  logic             slot_en;
  logic             snoop_rd;
  logic             snoop_wr;
  logic             sweep_slot;
  logic             cpu_slot;

  assign slot_en = d_clk_en_h & ~proc_init_h;

  // Flush restarts the index from any state; sweep slots advance it.
  cak_sweep_ctr #(
    .IDX_W (IDX_W)
  ) u_sweep_ctr (
    .b_clk_l     (b_clk_l),
    .proc_init_h (proc_init_h),
    .restart_h   (slot_en & flush_req_h),
    .adv_h       (sweep_slot),
    .idx_h       (idx_q),
    .last_h      (last_h),
    .done_h      (done_h)
  );

  // Slot decode: snoop first, then a forced sweep slot when the CPU has
  // starved the sweep, then CPU, then an ordinary sweep slot.
  always_comb begin
    snoop_rd   = 1'b0;
    sweep_slot = 1'b0;
    cpu_slot   = 1'b0;
    snoop_wr   = slot_en & (state_q == ST_SNP_WR);
    if (slot_en && (state_q != ST_SNP_WR)) begin
      if (snoop_req_h) begin
        snoop_rd = 1'b1;
      end else if ((state_q == ST_SWEEP) && (st_q == ST_MAX)) begin
        sweep_slot = 1'b1;
      end else if (cpu_req_h) begin
        cpu_slot = 1'b1;
      end else if (state_q == ST_SWEEP) begin
        sweep_slot = 1'b1;
      end
    end
  end

  // Port drive: CPU index is the idle default; reset forces everything low.
  always_comb begin
    tag_sel_h   = SEL_CPU;
    tag_idx_h   = proc_init_h ? '0 : cpu_idx_h;
    grp_wr_h    = 2'b00;
    cpu_gnt_h   = cpu_slot;
    snoop_ack_h = snoop_wr;
    if (sweep_slot) begin
      tag_sel_h = SEL_SWEEP;
      tag_idx_h = idx_q;
      grp_wr_h  = 2'b11;
    end else if (snoop_rd || snoop_wr) begin
      tag_sel_h = SEL_SNOOP;
      tag_idx_h = snoop_idx_h;
      grp_wr_h  = snoop_wr ? hit_q : 2'b00;
    end
  end

  assign flush_busy_h = ~proc_init_h &
                        ((state_q == ST_SWEEP) || ((state_q == ST_SNP_WR) && ret_sweep_q));
  assign flush_done_h = ~proc_init_h & done_h;

  // Arbiter state: snoop read/write pair, sweep ownership and starve count.
  always_ff @(posedge b_clk_l) begin
    if (proc_init_h) begin
      state_q     <= ST_IDLE;
      st_q        <= '0;
      hit_q       <= 2'b00;
      ret_sweep_q <= 1'b0;
    end else if (d_clk_en_h) begin
      case (state_q)
        ST_IDLE, ST_SWEEP: begin
          if (snoop_rd) begin
            hit_q       <= hit_h;
            ret_sweep_q <= (state_q == ST_SWEEP) | flush_req_h;
            state_q     <= ST_SNP_WR;
          end else begin
            if (sweep_slot) begin
              st_q <= '0;
              if (last_h) begin
                state_q <= ST_IDLE;
              end
            end else if (cpu_slot && (state_q == ST_SWEEP) && (st_q != ST_MAX)) begin
              st_q <= st_q + ST_W'(1);
            end
            // A flush keeps (or puts) us in SWEEP, cancelling a wrap to IDLE.
            if (flush_req_h) begin
              state_q <= ST_SWEEP;
              if (state_q == ST_IDLE) begin
                st_q <= '0;
              end
            end
          end
        end
        ST_SNP_WR: begin
          state_q <= ret_sweep_q ? ST_SWEEP : ST_IDLE;
          if (flush_req_h) begin
            ret_sweep_q <= 1'b1;
            state_q     <= ST_SWEEP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cak_tag_port_arb.sv
// Self-checking bench for cak_tag_port_arb: directed vector table, hand
// sequences for sweep/starve/restart, and random traffic against a model.
module tb_cak_tag_port_arb;

  localparam int IW     = 6;
  localparam int SMAX   = 4;
  localparam int NLINES = 1 << IW;

  logic          b_clk_l;
  logic          proc_init_h;
  logic          d_clk_en_h;
  logic          flush_req_h;
  logic          snoop_req_h;
  logic [IW-1:0] snoop_idx_h;
  logic [1:0]    hit_h;
  logic          cpu_req_h;
  logic [IW-1:0] cpu_idx_h;
  logic [IW-1:0] tag_idx_h;
  logic [1:0]    tag_sel_h;
  logic [1:0]    grp_wr_h;
  logic          cpu_gnt_h;
  logic          snoop_ack_h;
  logic          flush_busy_h;
  logic          flush_done_h;

  int checks = 0;
  int errors = 0;

  cak_tag_port_arb #(
    .IDX_W      (IW),
    .STARVE_MAX (SMAX)
  ) dut (
    .b_clk_l      (b_clk_l),
    .proc_init_h  (proc_init_h),
    .d_clk_en_h   (d_clk_en_h),
    .flush_req_h  (flush_req_h),
    .snoop_req_h  (snoop_req_h),
    .snoop_idx_h  (snoop_idx_h),
    .hit_h        (hit_h),
    .cpu_req_h    (cpu_req_h),
    .cpu_idx_h    (cpu_idx_h),
    .tag_idx_h    (tag_idx_h),
    .tag_sel_h    (tag_sel_h),
    .grp_wr_h     (grp_wr_h),
    .cpu_gnt_h    (cpu_gnt_h),
    .snoop_ack_h  (snoop_ack_h),
    .flush_busy_h (flush_busy_h),
    .flush_done_h (flush_done_h)
  );

  initial b_clk_l = 1'b0;
  always #5 b_clk_l = ~b_clk_l;

  logic [13:0] obs;
  assign obs = {tag_sel_h, tag_idx_h, grp_wr_h, cpu_gnt_h, snoop_ack_h, flush_busy_h, flush_done_h};

  function automatic logic [13:0] pack(input logic [1:0] sel, input logic [IW-1:0] idx,
                                       input logic [1:0] wr, input logic gnt, input logic ack,
                                       input logic busy, input logic done);
    return {sel, idx, wr, gnt, ack, busy, done};
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got sel/idx/wr/gnt/ack/busy/done=%b_%h_%b_%b%b%b%b want %b_%h_%b_%b%b%b%b",
               nm, act[13:12], act[11:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[13:12], exp[11:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 idle, 1 sweeping, 2 second half of a snoop (the write)
  int          m_phase, m_line, m_streak;
  bit [1:0]    m_hit;
  bit          m_ret, m_done;
  int          n_phase, n_line, n_streak;
  bit [1:0]    n_hit;
  bit          n_ret, n_done;
  logic [13:0] e_vec;
  bit          e_ack;

  task automatic model_eval();
    int sel, idxv, wr;
    bit gnt, ack, busy, done, sweep_turn;
    n_phase = m_phase; n_line = m_line; n_streak = m_streak;
    n_hit = m_hit; n_ret = m_ret; n_done = 1'b0;
    sel = 0; idxv = int'(cpu_idx_h); wr = 0; gnt = 0; ack = 0;
    busy = (m_phase == 1) || (m_phase == 2 && m_ret);
    done = m_done;
    if (proc_init_h) begin
      idxv = 0; busy = 0; done = 0;
      n_phase = 0; n_line = 0; n_streak = 0; n_hit = 0; n_ret = 0;
    end else if (d_clk_en_h) begin
      if (m_phase == 2) begin
        sel = 2; idxv = int'(snoop_idx_h); wr = int'(m_hit); ack = 1;
        n_phase = m_ret ? 1 : 0;
        if (flush_req_h) begin n_phase = 1; n_ret = 1; n_line = 0; end
      end else begin
        sweep_turn = 0;
        if (snoop_req_h) begin
          sel = 2; idxv = int'(snoop_idx_h);
          n_hit = hit_h; n_ret = (m_phase == 1) || flush_req_h; n_phase = 2;
        end else if (m_phase == 1 && m_streak >= SMAX) begin
          sweep_turn = 1;
        end else if (cpu_req_h) begin
          gnt = 1;
          if (m_phase == 1) n_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
        end else if (m_phase == 1) begin
          sweep_turn = 1;
        end
        if (sweep_turn) begin
          sel = 1; idxv = m_line; wr = 3; n_streak = 0;
          if (m_line == NLINES - 1) begin n_line = 0; n_phase = 0; n_done = 1; end
          else n_line = m_line + 1;
        end
        if (flush_req_h) begin
          n_line = 0;
          if (m_phase == 0) n_streak = 0;
          if (!snoop_req_h) begin n_phase = 1; n_done = 0; end
        end
      end
    end
    e_ack = ack;
    e_vec = pack(2'(sel), IW'(idxv), 2'(wr), gnt, ack, busy, done);
  endtask

  task automatic model_commit();
    m_phase = n_phase; m_line = n_line; m_streak = n_streak;
    m_hit = n_hit; m_ret = n_ret; m_done = n_done;
  endtask

  // Inputs are set at the falling edge; outputs sampled 1ns later.
  task automatic eval_now();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge b_clk_l);
    model_commit();
    @(negedge b_clk_l);
  endtask

  task automatic idle_inputs();
    proc_init_h = 0; d_clk_en_h = 1; flush_req_h = 0; snoop_req_h = 0;
    snoop_idx_h = '0; hit_h = 2'b00; cpu_req_h = 0; cpu_idx_h = '0;
  endtask

  typedef struct {
    logic          rst, en, flush, snoop;
    logic [IW-1:0] sidx;
    logic [1:0]    hit;
    logic          cpu;
    logic [IW-1:0] cidx;
    logic [1:0]    sel;
    logic [IW-1:0] idx;
    logic [1:0]    wr;
    logic          gnt, ack, busy, done;
  } vec_t;

  vec_t tbl[12];
  bit   snp_pend;
  int   done_cnt;

  initial begin
    m_phase = 0; m_line = 0; m_streak = 0; m_hit = 0; m_ret = 0; m_done = 0;
    idle_inputs();
    proc_init_h = 1;

    //           rst en fl sn sidx   hit    cpu cidx   | sel    idx    wr    gnt ack busy done
    tbl[0]  = '{1, 1, 1, 0, 6'h00, 2'b00, 1, 6'h05, 2'b00, 6'h00, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 6'h00, 2'b00, 1, 6'h07, 2'b00, 6'h07, 2'b00, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 6'h00, 2'b00, 1, 6'h03, 2'b00, 6'h03, 2'b00, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 6'h00, 2'b00, 0, 6'h00, 2'b01, 6'h00, 2'b11, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 0, 6'h00, 2'b00, 1, 6'h09, 2'b00, 6'h09, 2'b00, 1, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 6'h2A, 2'b10, 1, 6'h09, 2'b10, 6'h2A, 2'b00, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 1, 6'h2A, 2'b00, 1, 6'h09, 2'b10, 6'h2A, 2'b10, 0, 1, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 6'h00, 2'b00, 0, 6'h00, 2'b01, 6'h01, 2'b11, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 6'h00, 2'b00, 1, 6'h04, 2'b00, 6'h04, 2'b00, 0, 0, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 6'h00, 2'b00, 0, 6'h00, 2'b01, 6'h02, 2'b11, 0, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 6'h00, 2'b00, 1, 6'h13, 2'b00, 6'h00, 2'b00, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 6'h00, 2'b00, 0, 6'h11, 2'b00, 6'h11, 2'b00, 0, 0, 0, 0};

    @(negedge b_clk_l);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      proc_init_h = tbl[i].rst;  d_clk_en_h = tbl[i].en;   flush_req_h = tbl[i].flush;
      snoop_req_h = tbl[i].snoop; snoop_idx_h = tbl[i].sidx; hit_h = tbl[i].hit;
      cpu_req_h   = tbl[i].cpu;   cpu_idx_h = tbl[i].cidx;
      eval_now();
      check($sformatf("table[%0d]", i), obs,
            pack(tbl[i].sel, tbl[i].idx, tbl[i].wr, tbl[i].gnt, tbl[i].ack, tbl[i].busy, tbl[i].done));
      advance();
    end

    // Uncontended sweep: every set written once, then a single done pulse
    idle_inputs();
    flush_req_h = 1; eval_now(); advance(); flush_req_h = 0;
    for (int i = 0; i < NLINES; i++) begin
      eval_now();
      check($sformatf("sweep_idx%0d", i), obs, pack(2'b01, IW'(i), 2'b11, 0, 0, 1, 0));
      advance();
    end
    eval_now(); check("sweep_done", obs, pack(2'b00, '0, 2'b00, 0, 0, 0, 1)); advance();
    eval_now(); check("sweep_after", obs, pack(2'b00, '0, 2'b00, 0, 0, 0, 0)); advance();

    // CPU held high during a sweep: four grants then one forced sweep slot
    flush_req_h = 1; eval_now(); advance(); flush_req_h = 0;
    cpu_req_h = 1; cpu_idx_h = 6'h15;
    for (int k = 0; k < 25; k++) begin
      eval_now();
      if (k % 5 == 4)
        check($sformatf("starve_k%0d", k), obs, pack(2'b01, IW'(k / 5), 2'b11, 0, 0, 1, 0));
      else
        check($sformatf("starve_k%0d", k), obs, pack(2'b00, 6'h15, 2'b00, 1, 0, 1, 0));
      advance();
    end
    // Reset mid-sweep abandons the pass
    proc_init_h = 1; eval_now(); advance(); idle_inputs();
    eval_now(); check("reset_abandon", obs, pack(2'b00, '0, 2'b00, 0, 0, 0, 0)); advance();

    // Flush during the idx 5 slot restarts the pass; only the full pass signals done
    flush_req_h = 1; eval_now(); advance(); flush_req_h = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) flush_req_h = 1;
      eval_now();
      check($sformatf("pre_restart%0d", i), obs, pack(2'b01, IW'(i), 2'b11, 0, 0, 1, 0));
      advance();
    end
    flush_req_h = 0;
    for (int i = 0; i < NLINES; i++) begin
      eval_now();
      check($sformatf("restart_idx%0d", i), obs, pack(2'b01, IW'(i), 2'b11, 0, 0, 1, 0));
      advance();
    end
    eval_now(); check("restart_done", obs, pack(2'b00, '0, 2'b00, 0, 0, 0, 1)); advance();
    eval_now(); check("restart_after", obs, pack(2'b00, '0, 2'b00, 0, 0, 0, 0)); advance();

    // Random traffic against the reference model
    proc_init_h = 1; eval_now(); advance();
    snp_pend = 0; done_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      proc_init_h = ($urandom_range(0, 499) == 0);
      d_clk_en_h  = ($urandom_range(0, 9) < 8);
      flush_req_h = ($urandom_range(0, 299) == 0);
      if (!snp_pend && $urandom_range(0, 7) == 0) begin
        snp_pend = 1; snoop_idx_h = IW'($urandom);
      end
      snoop_req_h = snp_pend;
      hit_h       = 2'($urandom);
      cpu_req_h   = 1'($urandom);
      cpu_idx_h   = IW'($urandom);
      eval_now();
      check($sformatf("random_c%0d", c), obs, e_vec);
      if (e_ack) snp_pend = 0;
      if (flush_done_h) done_cnt++;
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
